music_sec_timer: RTL
====================

MUSIC_SEC_TIMER -- requirements
Module: music_sec_timer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, CLK cycles per one-second tick (minimum 2).
REQ-002 CLK  input  1  system clock, 50 MHz; all logic is on its rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  level sampled each cycle; starts counting or resumes it.
REQ-005 Pause  input  1  level sampled each cycle; freezes the count.
REQ-006 Clear  input  1  level sampled each cycle; returns to 00/IDLE.
REQ-007 Limit_Tens  input  4  BCD tens digit of the stop time.
REQ-008 Limit_Ones  input  4  BCD ones digit of the stop time.
REQ-009 TimerL  output  4  BCD tens digit of elapsed seconds; feeds the display block.
REQ-010 TimerR  output  4  BCD ones digit of elapsed seconds; feeds the display block.
REQ-011 Running  output  1  high exactly while in RUN.
REQ-012 Done  output  1  one-cycle pulse when the limit is reached.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, all registered.
REQ-014 Command priority SHALL be Clear > Pause > Start when several are high in the same cycle.
REQ-015 Clear in any state SHALL, next cycle: state IDLE, TimerL=TimerR=0, prescaler=0.
REQ-016 IDLE + Start SHALL, next cycle: enter RUN with prescaler=0 and count 00.
REQ-017 In RUN the prescaler SHALL count 0..TICK_DIV-1 and wrap; the wrap cycle is the tick.
REQ-018 The first tick SHALL occur TICK_DIV cycles after entering RUN from IDLE.
REQ-019 On each tick, TimerR SHALL increment; at TimerR=9 it SHALL wrap to 0 and TimerL SHALL increment.
REQ-020 On the tick at 99, the count SHALL wrap to 00 when the limit is free-run.
REQ-021 TimerL/TimerR SHALL only ever hold values 0-9.
REQ-022 RUN + Pause SHALL, next cycle: enter PAUSE; prescaler and count held unchanged.
REQ-023 PAUSE + Start (Pause low) SHALL resume RUN from the held prescaler value, so no time is lost or gained.
REQ-024 Limit SHALL be compared every cycle; a limit of 00 or any digit >9 means free-run.
REQ-025 On a tick whose new count equals a valid non-zero limit, the FSM SHALL enter DONE and pulse Done for exactly one cycle.
REQ-026 In DONE, the count SHALL hold at the limit value and Running=0.
REQ-027 DONE + Start SHALL restart RUN from 00 with prescaler=0.
REQ-028 Pause in IDLE/DONE and Start in RUN SHALL be ignored.
REQ-029 A limit changed to a value already passed SHALL NOT stop the count until wrap-around reaches it.
REQ-030 All outputs SHALL be registered; there is no combinational input-to-output path.

Reset
REQ-031 On RST: state=IDLE, prescaler=0, TimerL=0, TimerR=0, Running=0, Done=0.
REQ-032 RST SHALL override all commands, including mid-RUN, on the same clock edge.
REQ-033 After RST drops, the block SHALL react to Start in the very next cycle.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding (2 bits), the BCD_MAX=9 constant and the free-run limit code 00.
REQ-035 The prescaler SHALL be a sub-module sec_tick_gen with ports CLK, RST, enable, clear and tick; its width is derived from TICK_DIV.
REQ-036 The BCD count, the FSM and the limit compare SHALL live in music_sec_timer.

Verification (TICK_DIV=4)
REQ-037 RST, then Start for 1 cycle, limit 00 -> Running=1 next cycle; TimerR=1 after 4 cycles; after 40 cycles TimerL=1, TimerR=0.
REQ-038 Free-run preloaded to 99 (by running 396 cycles) -> next tick gives 00 and no Done pulse.
REQ-039 Limit 0/5 -> after 20 RUN cycles count=05, Done high for exactly 1 cycle, Running=0, count held for 100 more cycles.
REQ-040 Pause at prescaler=2 held 10 cycles, then Start -> the next tick occurs 2 cycles after RUN resumes.
REQ-041 Start, Pause and Clear high in the same cycle while in RUN -> IDLE, count 00; RST at count 37 -> all outputs 0 next cycle.
REQ-042 Limit digits A/3 -> treated as free-run; count passes 13 without a Done pulse.

Source files
------------

// File: rtl/music_sec_timer_pkg.sv
// music_sec_timer_pkg: shared FSM encoding, BCD bound and limit helpers for the seconds timer
package music_sec_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [7:0] FREE_RUN_LIMIT = 8'h00;

    // A limit stops the count only when both digits are real BCD and it is not 00
    function automatic logic limit_is_valid(input logic [3:0] tens, input logic [3:0] ones);
        return tens <= BCD_MAX && ones <= BCD_MAX && {tens, ones} != FREE_RUN_LIMIT;
    endfunction

endpackage

// File: rtl/music_sec_timer_sec_tick_gen.sv
// sec_tick_gen: prescaler counting 0..TICK_DIV-1 while enabled, tick on the wrap cycle
// Ports: CLK clock, RST sync reset, enable advance, clear force to 0, tick wrap strobe
module sec_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] cnt;

    assign tick = enable && cnt == W'(TICK_DIV - 1);

    // A disabled prescaler holds its value so a paused second resumes where it stopped
    always_ff @(posedge CLK) begin
        if (RST || clear)
            cnt <= '0;
        else if (enable)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/music_sec_timer.sv
// music_sec_timer: BCD seconds stopwatch with start/pause/clear and a stop limit
// Ports: CLK, RST sync reset; Start/Pause/Clear level commands; Limit_Tens/Limit_Ones BCD stop time;
//        TimerL/TimerR BCD elapsed seconds; Running high in RUN; Done one-cycle pulse at the limit
module music_sec_timer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Clear,
    input  logic [3:0] Limit_Tens,
    input  logic [3:0] Limit_Ones,
    output logic [3:0] TimerL,
    output logic [3:0] TimerR,
    output logic       Running,
    output logic       Done
);
    import music_sec_timer_pkg::*;

    state_t     state, state_n;
    logic [3:0] tens_n, ones_n, inc_tens, inc_ones;
    logic       done_n, tick, presc_en, presc_clr, go;

    // Pause outranks Start in every state, so Start acts only with Pause low
    assign go        = Start && !Pause;
    assign presc_en  = state == RUN && !Clear && !Pause;
    assign presc_clr = Clear || ((state == IDLE || state == DONE) && go);

    sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK    (CLK),
        .RST    (RST),
        .enable (presc_en),
        .clear  (presc_clr),
        .tick   (tick)
    );

    assign inc_ones = TimerR == BCD_MAX ? 4'd0 : TimerR + 4'd1;
    assign inc_tens = TimerR != BCD_MAX ? TimerL : TimerL == BCD_MAX ? 4'd0 : TimerL + 4'd1;

    always_comb begin
        state_n = state;
        tens_n  = TimerL;
        ones_n  = TimerR;
        done_n  = 1'b0;
        if (Clear) begin
            state_n = IDLE;
            tens_n  = 4'd0;
            ones_n  = 4'd0;
        end else begin
            case (state)
                IDLE, DONE: if (go) begin
                    state_n = RUN;
                    tens_n  = 4'd0;
                    ones_n  = 4'd0;
                end
                RUN: if (Pause) begin
                    state_n = PAUSE;
                end else if (tick) begin
                    tens_n = inc_tens;
                    ones_n = inc_ones;
                    // Only the count just reached can stop us, so a limit already passed waits for wrap-around
                    if (limit_is_valid(Limit_Tens, Limit_Ones) && {inc_tens, inc_ones} == {Limit_Tens, Limit_Ones}) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
                PAUSE: if (go) state_n = RUN;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            TimerL  <= 4'd0;
            TimerR  <= 4'd0;
            Running <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state   <= state_n;
            TimerL  <= tens_n;
            TimerR  <= ones_n;
            Running <= state_n == RUN;
            Done    <= done_n;
        end
    end

endmodule
